multicycle_core: RTL

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with word-addressed handshaked memories.
// Optional feature: define MULTICYCLE_CORE_BNE_EN to support bne (opcode 0x05); otherwise 0x05 halts.
module multicycle_core #(
    parameter int unsigned     DATA_W   = 32,
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     NUM_REGS = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic              halted,
    output logic [PC_W-1:0]   pc_o
);

    localparam int unsigned REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [5:0]          opcode, funct;
    logic [REG_AW-1:0]   rs_idx, rt_idx, rd_idx, wr_idx;
    logic [DATA_W-1:0]   simm, alu_res;
    logic [PC_W-1:0]     pc_plus1, br_target, j_target;
    logic                legal, rf_we;
    logic                unused_shamt;

    assign opcode       = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign rs_idx       = instr_q[21 +: REG_AW];
    assign rt_idx       = instr_q[16 +: REG_AW];
    assign rd_idx       = instr_q[11 +: REG_AW];
    assign wr_idx       = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign simm         = DATA_W'($signed(instr_q[15:0]));
    assign pc_plus1     = pc_q + PC_W'(1);
    assign br_target    = pc_plus1 + PC_W'($signed(instr_q[15:0]));
    assign j_target     = PC_W'(instr_q[25:0]);
    assign unused_shamt = ^instr_q[10:6];

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MULTICYCLE_CORE_BNE_EN
            OP_BNE:   legal = 1'b1;
`endif
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = a_q + b_q;
        case (funct)
            F_SUB:   alu_res = a_q - b_q;
            F_AND:   alu_res = a_q & b_q;
            F_OR:    alu_res = a_q | b_q;
            F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_res = a_q + b_q;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        addr_d   = addr_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        retire   = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Gated by rst_n so the fetch request stays low while reset is held.
                imem_req = rst_n;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = regs_q[rs_idx];
                b_d     = regs_q[rt_idx];
                state_d = legal ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin res_d = alu_res;    state_d = ST_WB; end
                    OP_ADDI:  begin res_d = a_q + simm; state_d = ST_WB; end
                    OP_LW, OP_SW: begin
                        addr_d  = PC_W'(a_q + simm);
                        state_d = ST_MEM;
                    end
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? br_target : pc_plus1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
`ifdef MULTICYCLE_CORE_BNE_EN
                    OP_BNE: begin
                        pc_d    = (a_q != b_q) ? br_target : pc_plus1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
`endif
                    OP_J: begin
                        pc_d    = j_target;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        pc_d    = pc_plus1;
                        state_d = ST_FETCH;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                pc_d    = pc_plus1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
        end
    end

    // NOTE: the register file is architecturally cleared by reset, so the array is reset here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else if (rf_we && (wr_idx != '0)) begin
            regs_q[wr_idx] <= res_q;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = b_q;
    assign dmem_we    = dmem_req && (opcode == OP_SW);
    assign halted     = (state_q == ST_HALT);
    assign pc_o       = pc_q;

endmodule
